// File: rtl/modulo_reservatorio_rolhas.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : modulo_reservatorio_rolhas                                       |
// | Purpose  : Cork supply manager. Keeps a reserve stock (operator add/remove)|
// |            and a dispenser stock (consumed by sealing). It refills the     |
// |            dispenser from the reserve one cork per clock while it is low.  |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module modulo_reservatorio_rolhas #(
    parameter int W         = 7,
    parameter int CAP_MAIN  = 99,
    parameter int CAP_RES   = 99,
    parameter int MIN_MAIN  = 5,
    parameter int REFILL_TO = 20
) (
    input  logic         clk,
    input  logic         Nclr,
    input  logic         op_valid,
    input  logic         op_sub,
    input  logic [W-1:0] op_qty,
    input  logic         consume,
    output logic         op_ack,
    output logic         op_err,
    output logic [W-1:0] main_count,
    output logic [W-1:0] res_count,
    output logic         ro,
    output logic         low,
    output logic         xfer_busy
);

    // Thresholds carried one bit wider so all count arithmetic is overflow-free
    localparam logic [W:0] c_cap_main  = (W+1)'(CAP_MAIN);
    localparam logic [W:0] c_cap_res   = (W+1)'(CAP_RES);
    localparam logic [W:0] c_min_main  = (W+1)'(MIN_MAIN);
    localparam logic [W:0] c_refill_to = (W+1)'(REFILL_TO);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_OP_APPLY = 2'd1,
        S_XFER     = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic           r_op_prev;
    logic           r_cap_sub;
    logic [W-1:0]   r_cap_qty;
    logic           r_pend;

    logic           w_op_edge;
    logic [W:0]     w_main_ext;
    logic [W:0]     w_res_ext;
    logic [W:0]     w_sum;
    logic           w_inc;
    logic           w_dec;
    logic [W:0]     w_main_next;
    logic [W:0]     w_res_next;
    logic           w_ack_next;
    logic           w_err_next;
    logic           w_cap_load;
    logic           w_pend_next;
    logic           w_xfer_done;

    assign w_op_edge  = op_valid & ~r_op_prev;
    assign w_main_ext = {1'b0, main_count};
    assign w_res_ext  = {1'b0, res_count};
    assign w_sum      = w_res_ext + {1'b0, r_cap_qty};

    // A cork moves only while transferring, with reserve stock and dispenser room left
    assign w_inc = (r_state == S_XFER) && (res_count != '0)
                && (w_main_ext < c_refill_to) && (w_main_ext < c_cap_main);
    // Sealing takes one cork per cycle; an empty dispenser ignores it
    assign w_dec = consume && (main_count != '0);
    assign w_main_next = w_main_ext + {{W{1'b0}}, w_inc} - {{W{1'b0}}, w_dec};

    // State register
    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, reserve update and response pulses
    always_comb begin
        w_state_next = r_state;
        w_res_next   = w_res_ext;
        w_ack_next   = 1'b0;
        w_err_next   = 1'b0;
        w_cap_load   = 1'b0;
        w_pend_next  = r_pend;
        w_xfer_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Operator request wins over starting a refill
                if (w_op_edge) begin
                    w_cap_load   = 1'b1;
                    w_state_next = S_OP_APPLY;
                end else if (low && (res_count != '0)) begin
                    w_state_next = S_XFER;
                end
            end
            S_OP_APPLY: begin
                if (r_cap_sub) begin
                    if ({1'b0, r_cap_qty} > w_res_ext) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_res_next = w_res_ext - {1'b0, r_cap_qty};
                        w_ack_next = 1'b1;
                    end
                end else begin
                    if (w_sum > c_cap_res) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_res_next = w_sum;
                        w_ack_next = 1'b1;
                    end
                end
                // A request arriving as a queued one is applied is chained behind it
                if (w_op_edge) begin
                    w_cap_load   = 1'b1;
                    w_state_next = S_OP_APPLY;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_XFER: begin
                if (w_inc) begin
                    w_res_next = w_res_ext - {{W{1'b0}}, 1'b1};
                end
                // Single pending slot: a second request while one waits is rejected
                if (w_op_edge) begin
                    if (r_pend) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_cap_load  = 1'b1;
                        w_pend_next = 1'b1;
                    end
                end
                w_xfer_done = (w_main_next >= c_refill_to) || (w_res_next == '0)
                           || (w_main_next >= c_cap_main);
                if (w_xfer_done) begin
                    if (w_pend_next) begin
                        w_pend_next  = 1'b0;
                        w_state_next = S_OP_APPLY;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Registered counts, flags and operand capture
    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            r_op_prev  <= 1'b1;
            r_cap_sub  <= 1'b0;
            r_cap_qty  <= '0;
            r_pend     <= 1'b0;
            main_count <= '0;
            res_count  <= '0;
            ro         <= 1'b1;
            low        <= (MIN_MAIN != 0);
            op_ack     <= 1'b0;
            op_err     <= 1'b0;
            xfer_busy  <= 1'b0;
        end else begin
            r_op_prev  <= op_valid;
            if (w_cap_load) begin
                r_cap_sub <= op_sub;
                r_cap_qty <= op_qty;
            end
            r_pend     <= w_pend_next;
            main_count <= w_main_next[W-1:0];
            res_count  <= w_res_next[W-1:0];
            ro         <= (w_main_next == '0);
            low        <= (w_main_next < c_min_main);
            op_ack     <= w_ack_next;
            op_err     <= w_err_next;
            xfer_busy  <= (w_state_next == S_XFER);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_modulo_reservatorio_rolhas.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_modulo_reservatorio_rolhas                                   |
// | Purpose  : Self-checking bench: directed scenarios plus random traffic,    |
// |            scored against a behavioural stock model.                       |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_modulo_reservatorio_rolhas;

    localparam int W         = 7;
    localparam int CAP_MAIN  = 99;
    localparam int CAP_RES   = 99;
    localparam int MIN_MAIN  = 5;
    localparam int REFILL_TO = 20;

    logic         clk = 1'b0;
    logic         Nclr;
    logic         op_valid;
    logic         op_sub;
    logic [W-1:0] op_qty;
    logic         consume;
    logic         op_ack;
    logic         op_err;
    logic [W-1:0] main_count;
    logic [W-1:0] res_count;
    logic         ro;
    logic         low;
    logic         xfer_busy;

    modulo_reservatorio_rolhas #(
        .W(W), .CAP_MAIN(CAP_MAIN), .CAP_RES(CAP_RES),
        .MIN_MAIN(MIN_MAIN), .REFILL_TO(REFILL_TO)
    ) dut (
        .clk(clk), .Nclr(Nclr), .op_valid(op_valid), .op_sub(op_sub),
        .op_qty(op_qty), .consume(consume), .op_ack(op_ack), .op_err(op_err),
        .main_count(main_count), .res_count(res_count), .ro(ro), .low(low),
        .xfer_busy(xfer_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_ack_seen = 0;
    int n_err_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit err;
        int res;
    } resp_t;
    resp_t exp_q[$];

    int m_main = 0, m_res = 0, m_qty = 0;
    bit m_sub = 0, m_prev = 1, m_pend = 0;
    bit m_apply = 0;      // a captured request gets applied at the next edge
    bit m_refill = 0;     // dispenser is being refilled from the reserve
    int nm, nr;
    bit e_seen, ok, nxt_apply, nxt_refill;
    resp_t r_tmp;

    always @(posedge clk) begin
        if (!Nclr) begin
            m_main = 0; m_res = 0; m_qty = 0; m_sub = 0;
            m_prev = 1; m_pend = 0; m_apply = 0; m_refill = 0;
            exp_q.delete();
        end else begin
            e_seen = op_valid && !m_prev;
            m_prev = op_valid;
            nm = m_main;
            nr = m_res;
            nxt_apply  = 0;
            nxt_refill = m_refill;
            if (m_apply) begin
                ok = m_sub ? (m_qty <= m_res) : (m_res + m_qty <= CAP_RES);
                if (ok) nr = m_sub ? m_res - m_qty : m_res + m_qty;
                r_tmp.err = !ok;
                r_tmp.res = nr;
                exp_q.push_back(r_tmp);
                if (e_seen) begin
                    m_sub = op_sub; m_qty = op_qty; nxt_apply = 1;
                end
            end else if (m_refill) begin
                if (m_res > 0 && m_main < REFILL_TO && m_main < CAP_MAIN) begin
                    nr = nr - 1;
                    nm = nm + 1;
                end
                if (e_seen) begin
                    if (m_pend) begin
                        r_tmp.err = 1;
                        r_tmp.res = nr;
                        exp_q.push_back(r_tmp);
                    end else begin
                        m_sub = op_sub; m_qty = op_qty; m_pend = 1;
                    end
                end
            end else begin
                if (e_seen) begin
                    m_sub = op_sub; m_qty = op_qty; nxt_apply = 1;
                end else if (m_main < MIN_MAIN && m_res > 0) begin
                    nxt_refill = 1;
                end
            end
            if (consume && m_main > 0) nm = nm - 1;
            if (m_refill && (nm >= REFILL_TO || nr == 0 || nm >= CAP_MAIN)) begin
                nxt_refill = 0;
                if (m_pend) begin
                    nxt_apply = 1;
                    m_pend = 0;
                end
            end
            m_main   = nm;
            m_res    = nr;
            m_apply  = nxt_apply;
            m_refill = nxt_refill;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    resp_t r_got;
    always @(posedge clk) begin
        #1;
        if (op_ack) n_ack_seen++;
        if (op_err) n_err_seen++;
        chk("mon_main", main_count, m_main);
        chk("mon_res", res_count, m_res);
        chk("mon_ro", ro, (m_main == 0));
        chk("mon_low", low, (m_main < MIN_MAIN));
        chk("mon_busy", xfer_busy, m_refill);
        if (exp_q.size() > 0) begin
            r_got = exp_q.pop_front();
            chk("resp_ack", op_ack, !r_got.err);
            chk("resp_err", op_err, r_got.err);
            chk("resp_res", res_count, r_got.res);
        end else begin
            chk("quiet_ack", op_ack, 0);
            chk("quiet_err", op_err, 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_op(input bit sub, input int qty);
        op_sub   = sub;
        op_qty   = W'(qty);
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
    endtask

    int snap_ack, snap_err;

    initial begin
        Nclr = 1'b0; op_valid = 1'b0; op_sub = 1'b0; op_qty = '0; consume = 1'b0;
        repeat (3) tick();
        chk("rst_main", main_count, 0);
        chk("rst_res", res_count, 0);
        chk("rst_ro", ro, 1);
        chk("rst_low", low, 1);
        chk("rst_ack", op_ack, 0);
        chk("rst_busy", xfer_busy, 0);
        Nclr = 1'b1;
        tick();

        // add 30, then automatic refill up to 20
        do_op(0, 30);
        chk("s1_ack", op_ack, 1);
        chk("s1_res", res_count, 30);
        tick();
        chk("s1_busy_on", xfer_busy, 1);
        repeat (19) tick();
        chk("s1_main19", main_count, 19);
        tick();
        chk("s1_main", main_count, 20);
        chk("s1_res10", res_count, 10);
        chk("s1_busy_off", xfer_busy, 0);
        chk("s1_low", low, 0);
        chk("s1_ro", ro, 0);

        // reserve capacity boundaries
        do_op(0, 85);
        chk("s2_res95", res_count, 95);
        do_op(0, 10);
        chk("s2_err_over", op_err, 1);
        chk("s2_res_keep", res_count, 95);
        do_op(0, 4);
        chk("s2_ack_full", op_ack, 1);
        chk("s2_res99", res_count, 99);
        do_op(1, 100);
        chk("s2_err_under", op_err, 1);
        chk("s2_res_keep99", res_count, 99);
        do_op(1, 99);
        chk("s2_ack_sub", op_ack, 1);
        chk("s2_res0", res_count, 0);

        // draining the dispenser with an empty reserve
        consume = 1'b1;
        repeat (14) tick();
        chk("s3_main6", main_count, 6);
        chk("s3_low6", low, 0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("s3_main", main_count, 6 - i);
            chk("s3_low", low, (6 - i) < MIN_MAIN);
            chk("s3_ro", ro, (6 - i) == 0);
        end
        repeat (3) tick();
        chk("s3_main_floor", main_count, 0);
        chk("s3_no_xfer", xfer_busy, 0);
        consume = 1'b0;

        // refill while sealing consumes every cycle
        do_op(0, 10);
        chk("s4_res", res_count, 10);
        consume = 1'b1;
        tick();
        chk("s4_busy", xfer_busy, 1);
        tick();
        chk("s4_main1", main_count, 1);
        chk("s4_res9", res_count, 9);
        for (int j = 8; j >= 0; j--) begin
            tick();
            chk("s4_main_hold", main_count, 1);
            chk("s4_res_fall", res_count, j);
        end
        chk("s4_busy_off", xfer_busy, 0);
        consume = 1'b0;

        // request queued during refill, second one rejected
        do_op(0, 30);
        chk("s5_res30", res_count, 30);
        tick();
        snap_ack = n_ack_seen;
        snap_err = n_err_seen;
        do_op(0, 5);
        do_op(0, 3);
        repeat (20) tick();
        chk("s5_main", main_count, 20);
        chk("s5_res", res_count, 16);
        chk("s5_acks", n_ack_seen - snap_ack, 1);
        chk("s5_errs", n_err_seen - snap_err, 1);

        // asynchronous clear mid-refill with op_valid held through release
        consume = 1'b1;
        repeat (17) tick();
        consume = 1'b0;
        repeat (3) tick();
        op_sub = 1'b0; op_qty = W'(7); op_valid = 1'b1;
        tick();
        Nclr = 1'b0;
        #1;
        chk("s6_main", main_count, 0);
        chk("s6_res", res_count, 0);
        chk("s6_ro", ro, 1);
        chk("s6_busy", xfer_busy, 0);
        repeat (2) tick();
        Nclr = 1'b1;
        snap_ack = n_ack_seen;
        snap_err = n_err_seen;
        repeat (5) tick();
        chk("s6_no_ack", n_ack_seen - snap_ack, 0);
        chk("s6_no_err", n_err_seen - snap_err, 0);
        chk("s6_res_after", res_count, 0);
        op_valid = 1'b0;
        tick();
        do_op(0, 7);
        chk("s6_fresh_ack", op_ack, 1);
        chk("s6_fresh_res", res_count, 7);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            Nclr = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 3) == 0) op_valid = !op_valid;
            op_sub = 1'($urandom_range(0, 1));
            op_qty = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 127))
                                                 : W'($urandom_range(0, 40));
            consume = ($urandom_range(0, 9) < 3);
            tick();
        end
        Nclr = 1'b1; op_valid = 1'b0; consume = 1'b0;
        repeat (50) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
